// File: rtl/digest_unpacker.sv
// digest_unpacker: serializes a captured digest MSB-first into a UART TX handshake; define HEX_ASCII_EN to send lowercase ASCII hex
module digest_unpacker #(
    parameter int DIGEST_WIDTH   = 256,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DIGEST_WIDTH-1:0] digest_in,
    input  logic                    digest_valid,
    input  logic                    tx_active,
    input  logic                    tx_done,
    output logic [7:0]              tx_byte,
    output logic                    tx_dv,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err
);
`ifdef HEX_ASCII_EN
    localparam int CW = 4;
`else
    localparam int CW = 8;
`endif
    localparam int NCH = DIGEST_WIDTH / CW;
    localparam int IW  = NCH > 1 ? $clog2(NCH) : 1;
    localparam int TW  = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {s_IDLE, s_SEND, s_WAIT, s_DONE} state_t;

    state_t                  state, state_n;
    logic [IW-1:0]           idx, idx_n;
    logic [TW-1:0]           timer, timer_n;
    logic [7:0]              tx_byte_n;
    logic                    tx_dv_n, busy_n, done_n, err_n, capture;
    logic [DIGEST_WIDTH-1:0] shadow;
    logic [CW-1:0]           chunk;
    logic [7:0]              char_c;

    assign chunk = shadow[DIGEST_WIDTH-1-CW*int'(idx) -: CW];
`ifdef HEX_ASCII_EN
    assign char_c = chunk < 4'd10 ? 8'h30 + {4'd0, chunk} : 8'h57 + {4'd0, chunk};
`else
    assign char_c = chunk;
`endif

    // Next-state and next-output logic; strobes default low every cycle
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        timer_n   = timer;
        tx_byte_n = tx_byte;
        tx_dv_n   = 1'b0;
        busy_n    = busy;
        done_n    = 1'b0;
        err_n     = timeout_err;
        capture   = 1'b0;
        case (state)
            s_IDLE: if (digest_valid) begin
                capture = 1'b1;
                idx_n   = '0;
                busy_n  = 1'b1;
                err_n   = 1'b0;
                state_n = s_SEND;
            end
            s_SEND: if (!tx_active) begin
                tx_byte_n = char_c;
                tx_dv_n   = 1'b1;
                timer_n   = '0;
                state_n   = s_WAIT;
            end
            s_WAIT: if (tx_done) begin
                timer_n = '0;
                state_n = idx == IW'(NCH-1) ? s_DONE : s_SEND;
                idx_n   = idx == IW'(NCH-1) ? idx : idx + 1'b1;
            end else if (TIMEOUT_CYCLES != 0 && timer == TW'(TIMEOUT_CYCLES-1)) begin
                err_n   = 1'b1;
                busy_n  = 1'b0;
                state_n = s_IDLE;
            end else begin
                timer_n = timer + 1'b1;
            end
            s_DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = s_IDLE;
            end
            default: state_n = s_IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= s_IDLE;
            idx         <= '0;
            timer       <= '0;
            tx_byte     <= '0;
            tx_dv       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            timer       <= timer_n;
            tx_byte     <= tx_byte_n;
            tx_dv       <= tx_dv_n;
            busy        <= busy_n;
            done        <= done_n;
            timeout_err <= err_n;
        end
    end

    // Digest shadow copy, loaded only when a new digest is accepted
    always_ff @(posedge clk) begin
        if (capture) shadow <= digest_in;
    end
endmodule
